// File: rtl/ann_pkg.sv
// Shared ANN datapath definitions: word geometry, neuron FSM states and the
// fixed-point floor-shift/clamp helper used by every layer.
package ann_pkg;

  localparam int NEURON_SIZE   = 16;
  localparam int WORD_SIZE     = 16;
  localparam int NEURON_FRAC_W = 8;
  localparam int SAT_W         = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } neuron_state_e;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] value;
  } sat_res_t;

  // Floor shift by frac_w, then clamp into the signed word_w range.
  function automatic sat_res_t sat_word(input logic signed [SAT_W-1:0] acc,
                                        input int word_w,
                                        input int frac_w);
    sat_res_t                res;
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    shifted = acc >>> frac_w;
    hi      = (64'sd1 <<< (word_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (word_w - 1));
    if (shifted > hi) begin
      res.sat   = 1'b1;
      res.value = hi;
    end else if (shifted < lo) begin
      res.sat   = 1'b1;
      res.value = lo;
    end else begin
      res.sat   = 1'b0;
      res.value = shifted;
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_mac_lane.sv
// One multiplier lane of the time-multiplexed neuron: full-precision signed
// WORD_W x WORD_W product.
module neuron_mac_lane #(
  parameter int WORD_W = 16
) (
  input  logic signed [WORD_W-1:0]   a_i,
  input  logic signed [WORD_W-1:0]   b_i,
  output logic signed [2*WORD_W-1:0] prod_o
);

  assign prod_o = (2*WORD_W)'(a_i) * (2*WORD_W)'(b_i);

endmodule

// File: rtl/neuron_seq.sv
// Handshaked, time-multiplexed neuron: bias + dot product over LANES lanes per
// beat, then floor shift, clamp and activation (ReLU when NEURON_RELU_EN is defined).
module neuron_seq
  import ann_pkg::*;
#(
  parameter int N_INPUTS = NEURON_SIZE,
  parameter int WORD_W   = WORD_SIZE,
  parameter int LANES    = 4,
  parameter int FRAC_W   = NEURON_FRAC_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [N_INPUTS-1:0][WORD_W-1:0]  weights_i,
  input  logic [N_INPUTS-1:0][WORD_W-1:0]  x_i,
  input  logic [WORD_W-1:0]                bias_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [WORD_W-1:0]                result_o,
  output logic                             sat_o,
  output logic                             busy_o
);

  localparam int BEATS  = N_INPUTS / LANES;
  localparam int ACC_W  = 2*WORD_W + $clog2(N_INPUTS) + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  neuron_state_e                      state_r;
  neuron_state_e                      state_nxt_s;
  logic [N_INPUTS-1:0][WORD_W-1:0]    w_r;
  logic [N_INPUTS-1:0][WORD_W-1:0]    x_r;
  logic signed [ACC_W-1:0]            acc_r;
  logic [BEAT_W-1:0]                  beat_r;
  logic signed [2*WORD_W-1:0]         prod_s [LANES];
  logic signed [ACC_W-1:0]            lane_sum_s;
  logic [WORD_W:0]                    fin_s;
  logic [WORD_W-1:0]                  result_r;
  logic                               sat_r;
  logic                               out_valid_r;

  // Shift/clamp the accumulator and apply the activation; returns {sat, word}.
  function automatic logic [WORD_W:0] finish_word(input logic signed [ACC_W-1:0] acc);
    sat_res_t          res;
    logic [WORD_W-1:0] word;
    res  = sat_word(SAT_W'(acc), WORD_W, FRAC_W);
    word = res.value[WORD_W-1:0];
`ifdef NEURON_RELU_EN
    if (word[WORD_W-1]) begin
      word = '0;
    end else begin
      word = word;
    end
`endif
    return {res.sat, word};
  endfunction

  // Operand arrays shift down one beat per ACC cycle, so lane l always reads slot l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    neuron_mac_lane #(.WORD_W(WORD_W)) u_lane (
      .a_i    (w_r[l]),
      .b_i    (x_r[l]),
      .prod_o (prod_s[l])
    );
  end

  // Sum of this beat's lane products, sign-extended to accumulator width.
  always_comb begin
    lane_sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum_s = lane_sum_s + ACC_W'(prod_s[l]);
    end
  end

  // Final result word and saturation flag from the completed accumulator.
  always_comb begin
    fin_s = finish_word(acc_r);
  end

  // Next-state logic for the IDLE/ACC/FIN/OUT sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid_i) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (beat_r == BEAT_W'(BEATS - 1)) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = ACC;
        end
      end
      FIN: state_nxt_s = OUT;
      OUT: begin
        if (out_ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: capture operands, accumulate beats, register the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_r         <= '0;
      x_r         <= '0;
      acc_r       <= '0;
      beat_r      <= '0;
      result_r    <= '0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i) begin
            w_r    <= weights_i;
            x_r    <= x_i;
            acc_r  <= ACC_W'($signed(bias_i)) <<< FRAC_W;
            beat_r <= '0;
          end
        end
        ACC: begin
          acc_r  <= acc_r + lane_sum_s;
          beat_r <= beat_r + BEAT_W'(1);
          w_r    <= w_r >> (LANES * WORD_W);
          x_r    <= x_r >> (LANES * WORD_W);
        end
        FIN: begin
          result_r    <= fin_s[WORD_W-1:0];
          sat_r       <= fin_s[WORD_W];
          out_valid_r <= 1'b1;
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready_o  = (state_r == IDLE) && !rst_i;
  assign busy_o      = (state_r != IDLE);
  assign out_valid_o = out_valid_r;
  assign result_o    = result_r;
  assign sat_o       = sat_r;

endmodule

// File: tb/tb_neuron_seq.sv
// Directed bench for neuron_seq: table of uniform operand sets plus stall,
// lane-pairing and mid-accumulation reset sequences.
`timescale 1ns/1ps
module tb_neuron_seq;
  import ann_pkg::*;

  localparam int N = 16;
  localparam int W = 16;

  typedef logic [N-1:0][W-1:0] vec_t;

  typedef struct {
    string       name;
    logic [15:0] w;
    logic [15:0] x;
    logic [15:0] b;
    logic [15:0] exp_res;
    logic        exp_sat;
  } vec_rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  vec_t        weights = '0;
  vec_t        x = '0;
  logic [15:0] bias = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        sat;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  neuron_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .weights_i   (weights),
    .x_i         (x),
    .bias_i      (bias),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .sat_o       (sat),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] act_fn(input logic [15:0] v);
`ifdef NEURON_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic vec_t fill(input logic [15:0] v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  task automatic send(input vec_t w, input vec_t xv, input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", in_ready, 1'b1);
    weights  = w;
    x        = xv;
    bias     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_out(input string name);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 5);
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_ack", out_valid, 1'b0);
    check("in_ready_after_ack", in_ready, 1'b1);
    @(negedge clk);
  endtask

  vec_rec_t tbl [12];
  vec_t     ramp_w;
  vec_t     ramp_x;
  logic     seen;

  initial begin
    tbl[0]  = '{"pos_2x1",   16'h0200, 16'h0100, 16'h0000, 16'h2000, 1'b0};
    tbl[1]  = '{"neg_2x1",   16'hFE00, 16'h0100, 16'h0000, 16'hE000, 1'b0};
    tbl[2]  = '{"max_pos",   16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1};
    tbl[3]  = '{"max_neg",   16'h8001, 16'h7FFF, 16'h0000, 16'h8000, 1'b1};
    tbl[4]  = '{"bias_only", 16'h0000, 16'h0000, 16'h0180, 16'h0180, 1'b0};
    tbl[5]  = '{"neg_bias",  16'h0000, 16'h0000, 16'hFF80, 16'hFF80, 1'b0};
    tbl[6]  = '{"floor_pos", 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    tbl[7]  = '{"floor_neg", 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
    tbl[8]  = '{"edge_hi",   16'h0100, 16'h07FF, 16'h000F, 16'h7FFF, 1'b0};
    tbl[9]  = '{"over_hi",   16'h0100, 16'h07FF, 16'h0010, 16'h7FFF, 1'b1};
    tbl[10] = '{"edge_lo",   16'h0100, 16'hF800, 16'h0000, 16'h8000, 1'b0};
    tbl[11] = '{"over_lo",   16'h0100, 16'hF800, 16'hFFFF, 16'h8000, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_sat", sat, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    // Table of uniform operand sets
    for (int i = 0; i < 12; i++) begin
      send(fill(tbl[i].w), fill(tbl[i].x), tbl[i].b);
      wait_out(tbl[i].name);
      check({tbl[i].name, "_result"}, result, act_fn(tbl[i].exp_res));
      check({tbl[i].name, "_sat"}, sat, tbl[i].exp_sat);
      ack();
    end

    // Lane pairing: w[i]=i.0, x[i]=1.0 for i<8 else 0 -> 0+..+7 = 28.0
    for (int i = 0; i < N; i++) begin
      ramp_w[i] = 16'(i) << 8;
      ramp_x[i] = (i < 8) ? 16'h0100 : 16'h0000;
    end
    send(ramp_w, ramp_x, 16'h0000);
    wait_out("ramp");
    check("ramp_result", result, 16'h1C00);
    check("ramp_sat", sat, 1'b0);
    ack();

    // Output stall with a second set waiting
    send(fill(16'h0000), fill(16'h0000), 16'h0180);
    wait_out("stall");
    check("stall_result", result, 16'h0180);
    weights  = fill(16'h0200);
    x        = fill(16'h0100);
    bias     = 16'h0000;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("stall_valid_hold", out_valid, 1'b1);
      check("stall_result_hold", result, 16'h0180);
      check("stall_sat_hold", sat, 1'b0);
      check("stall_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("second_busy", busy, 1'b1);
    wait_out("second");
    check("second_result", result, 16'h2000);
    check("second_sat", sat, 1'b0);
    ack();

    // Reset during accumulation beat 2
    send(fill(16'h0200), fill(16'h0100), 16'h0000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("midrst_no_result", seen, 1'b0);
    @(negedge clk);
    send(fill(16'h0200), fill(16'h0100), 16'h0000);
    wait_out("after_rst");
    check("after_rst_result", result, 16'h2000);
    check("after_rst_sat", sat, 1'b0);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
